// File: rtl/outport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : outport_arbiter_pkg
// Description : Shared types for the per-outport wormhole arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package outport_arbiter_pkg;

  // Per-outport ownership state: free for arbitration, or held by one buffer
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage : outport_arbiter_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin pick: first set bit of req at or
//               after ptr, searching upward and wrapping to bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [N-1:0] upper;

  // Requests at or above the pointer get first chance
  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
  end

  // Lowest set bit of the upper slice wins; otherwise wrap to the lowest request
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = PW'(i);
    end
    if (|upper) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (upper[i]) idx = PW'(i);
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/outport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : outport_arbiter
// Description : Per-outport wormhole arbiter. Each outport picks one input
//               buffer round-robin and stays locked to it until that
//               packet's tail flit has been accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module outport_arbiter
  import outport_arbiter_pkg::*;
#(
  parameter int NUM_BUFFERS  = 5,
  parameter int NUM_OUTPORTS = 5,
  parameter int SEL_W        = $clog2(NUM_BUFFERS),
  parameter int PORT_W       = $clog2(NUM_OUTPORTS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_BUFFERS-1:0]                   req,
  input  logic [NUM_BUFFERS-1:0][PORT_W-1:0]       req_port,
  input  logic [NUM_BUFFERS-1:0]                   req_tail,
  input  logic [NUM_OUTPORTS-1:0]                  credit_avail,
  input  logic [NUM_OUTPORTS-1:0]                  flit_sent,
  output logic [NUM_OUTPORTS-1:0][SEL_W-1:0]       grant_sel,
  output logic [NUM_OUTPORTS-1:0]                  grant_en,
  output logic [NUM_BUFFERS-1:0]                   buf_pop,
  output logic [NUM_OUTPORTS-1:0]                  port_locked,
  output logic                                     protocol_err
);

  logic [NUM_OUTPORTS-1:0]             locked_all;
  logic [NUM_OUTPORTS-1:0][SEL_W-1:0]  owner_all;
  logic [NUM_BUFFERS-1:0]              owns_any;
  logic                                protocol_err_q;
  logic                                protocol_err_d;

  // A buffer already holding some port may not compete for another one
  always_comb begin
    owns_any = '0;
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      if (locked_all[p]) owns_any[owner_all[p]] = 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_OUTPORTS; p++) begin : g_port
    arb_state_t              state_q;
    arb_state_t              state_d;
    logic [SEL_W-1:0]        owner_q;
    logic [SEL_W-1:0]        owner_d;
    logic [SEL_W-1:0]        rr_ptr_q;
    logic [SEL_W-1:0]        rr_ptr_d;
    logic [NUM_BUFFERS-1:0]  cand;
    logic                    win_found;
    logic [SEL_W-1:0]        win_idx;
    logic                    owner_ready;

    // Candidates: buffers routed to this port that are not holding another port
    always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        cand[i] = req[i] && (req_port[i] == PORT_W'(p)) && !owns_any[i];
      end
    end

    rr_picker #(
      .N  (NUM_BUFFERS),
      .PW (SEL_W)
    ) u_pick (
      .req   (cand),
      .ptr   (rr_ptr_q),
      .found (win_found),
      .idx   (win_idx)
    );

    // Owner still presents a flit aimed at this port (it may have stalled)
    assign owner_ready    = req[owner_q] && (req_port[owner_q] == PORT_W'(p));
    assign grant_en[p]    = (state_q == LOCKED) && owner_ready && credit_avail[p];
    assign grant_sel[p]   = owner_q;
    assign port_locked[p] = (state_q == LOCKED);
    assign locked_all[p]  = (state_q == LOCKED);
    assign owner_all[p]   = owner_q;

    // Lock on a round-robin winner; release once the tail flit is accepted
    always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_d  = LOCKED;
            owner_d  = win_idx;
            rr_ptr_d = (win_idx == SEL_W'(NUM_BUFFERS - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        LOCKED: begin
          if (grant_en[p] && flit_sent[p] && req_tail[owner_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Per-port ownership registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= IDLE;
        owner_q  <= '0;
        rr_ptr_q <= '0;
      end else begin
        state_q  <= state_d;
        owner_q  <= owner_d;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end : g_port

  // Pop the owning buffer of every port whose flit was accepted
  always_comb begin
    buf_pop = '0;
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      if (grant_en[p] && flit_sent[p]) buf_pop[owner_all[p]] = 1'b1;
    end
  end

  // Sticky flag: an outport claimed acceptance of a flit it was never offered
  always_comb begin
    protocol_err_d = protocol_err_q || (|(flit_sent & ~grant_en));
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) protocol_err_q <= 1'b0;
    else     protocol_err_q <= protocol_err_d;
  end

  assign protocol_err = protocol_err_q;

endmodule : outport_arbiter
`default_nettype wire

// File: tb/tb_outport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_outport_arbiter
// Description : Randomized scoreboard bench for outport_arbiter with a
//               packet-level reference model and a directed round-robin run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outport_arbiter;

  localparam int NB = 5;
  localparam int NP = 5;
  localparam int SW = 3;
  localparam int PW = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NB-1:0]          req;
  logic [NB-1:0][PW-1:0]  req_port;
  logic [NB-1:0]          req_tail;
  logic [NP-1:0]          credit_avail;
  logic [NP-1:0]          flit_sent;
  logic [NP-1:0][SW-1:0]  grant_sel;
  logic [NP-1:0]          grant_en;
  logic [NB-1:0]          buf_pop;
  logic [NP-1:0]          port_locked;
  logic                   protocol_err;

  outport_arbiter #(
    .NUM_BUFFERS  (NB),
    .NUM_OUTPORTS (NP),
    .SEL_W        (SW),
    .PORT_W       (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_port     (req_port),
    .req_tail     (req_tail),
    .credit_avail (credit_avail),
    .flit_sent    (flit_sent),
    .grant_sel    (grant_sel),
    .grant_en     (grant_en),
    .buf_pop      (buf_pop),
    .port_locked  (port_locked),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dest;
    bit tail;
  } flit_t;

  typedef struct {
    logic [NP-1:0]          gen;
    logic [NP-1:0][SW-1:0]  sel;
    logic [NB-1:0]          pop;
    logic [NP-1:0]          lck;
    logic                   err;
  } exp_t;

  exp_t  exp_q[$];
  flit_t bq[NB][$];     // packets waiting in each input buffer
  int    owner[NP];     // -1 when the port is free
  int    ptr[NP];
  bit    m_err;

  int compared   = 0;
  int mismatched = 0;

  bit rr_cap = 1'b0;
  int rr_sel[$];
  int rr_cyc[$];
  int ncyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  // One clock of stimulus: mode 0 random, 1 round-robin contention on port 4,
  // 3 random flit_sent on any port (error injection)
  task automatic cycle(input int mode, input bit do_rst);
    bit            g[NP];
    bit            owned[NB];
    logic [NB-1:0] popv;
    exp_t          e;
    int            o;
    bit            hit;
    int            j;
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      if (bq[i].size() == 0) begin
        if (mode == 1) begin
          if (i == 0 || i == 1 || i == 3) bq[i].push_back('{4, 1'b1});
        end else if ($urandom_range(0, 2) == 0) begin
          int len;
          int d;
          len = $urandom_range(1, 5);
          d   = $urandom_range(0, NP - 1);
          for (int k = 0; k < len; k++) bq[i].push_back('{d, (k == len - 1)});
        end
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (bq[i].size() > 0) begin
        req[i]      = (mode != 0) || ($urandom_range(0, 7) != 0);
        req_port[i] = PW'(bq[i][0].dest);
        req_tail[i] = bq[i][0].tail;
      end else begin
        req[i]      = 1'b0;
        req_port[i] = '0;
        req_tail[i] = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) credit_avail[p] = (mode != 0) || ($urandom_range(0, 4) != 0);
    for (int p = 0; p < NP; p++) begin
      o    = owner[p];
      g[p] = 1'b0;
      if (o >= 0) begin
        if (req[o] && credit_avail[p]) g[p] = (bq[o][0].dest == p);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (mode == 3) flit_sent[p] = ($urandom_range(0, 2) == 0);
      else           flit_sent[p] = g[p] && (mode == 1 || $urandom_range(0, 3) != 0);
    end
    rst  = do_rst;
    popv = '0;
    for (int p = 0; p < NP; p++) begin
      e.gen[p] = g[p];
      e.lck[p] = (owner[p] >= 0);
      e.sel[p] = (owner[p] >= 0) ? SW'(owner[p]) : '0;
      if (g[p] && flit_sent[p]) popv[owner[p]] = 1'b1;
    end
    e.pop = popv;
    e.err = m_err;
    exp_q.push_back(e);
    // advance the reference model to the next cycle
    for (int i = 0; i < NB; i++) owned[i] = 1'b0;
    for (int p = 0; p < NP; p++) if (owner[p] >= 0) owned[owner[p]] = 1'b1;
    for (int p = 0; p < NP; p++) begin
      o = owner[p];
      if (o >= 0) begin
        if (g[p] && flit_sent[p] && bq[o][0].tail) owner[p] = -1;
      end else begin
        hit = 1'b0;
        for (int k = 0; k < NB; k++) begin
          j = (ptr[p] + k) % NB;
          if (!hit && req[j] && !owned[j] && bq[j][0].dest == p) begin
            hit      = 1'b1;
            owner[p] = j;
            ptr[p]   = (j + 1) % NB;
          end
        end
      end
      if (flit_sent[p] && !g[p]) m_err = 1'b1;
    end
    for (int i = 0; i < NB; i++) if (popv[i]) void'(bq[i].pop_front());
    if (do_rst) begin
      for (int p = 0; p < NP; p++) begin
        owner[p] = -1;
        ptr[p]   = 0;
      end
      m_err = 1'b0;
      for (int i = 0; i < NB; i++) bq[i].delete();
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rr_cap && grant_en[4]) begin
        rr_sel.push_back(int'(grant_sel[4]));
        rr_cyc.push_back(ncyc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_en",     32'(grant_en),     32'(e.gen));
        check("buf_pop",      32'(buf_pop),      32'(e.pop));
        check("port_locked",  32'(port_locked),  32'(e.lck));
        check("protocol_err", 32'(protocol_err), 32'(e.err));
        for (int p = 0; p < NP; p++) begin
          if (e.gen[p]) check("grant_sel", 32'(grant_sel[p]), 32'(e.sel[p]));
        end
      end
    end
  end

  initial begin
    int rr_want[6];
    rr_want = '{0, 1, 3, 0, 1, 3};
    rst          = 1'b1;
    req          = '0;
    req_port     = '0;
    req_tail     = '0;
    credit_avail = '0;
    flit_sent    = '0;
    m_err        = 1'b0;
    for (int p = 0; p < NP; p++) begin
      owner[p] = -1;
      ptr[p]   = 0;
    end
    repeat (2) @(posedge clk);

    repeat (300) cycle(0, 1'b0);
    cycle(0, 1'b1);
    repeat (30) cycle(3, 1'b0);
    cycle(3, 1'b1);

    rr_cap = 1'b1;
    repeat (14) cycle(1, 1'b0);
    @(negedge clk);
    #1;
    rr_cap = 1'b0;
    check("rr_grant_count", 32'(rr_sel.size() >= 6), 32'd1);
    if (rr_sel.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check("rr_order", 32'(rr_sel[k]), 32'(rr_want[k]));
        if (k > 0) check("rr_spacing", 32'(rr_cyc[k] - rr_cyc[k-1]), 32'd2);
      end
    end

    repeat (300) cycle(0, 1'b0);
    cycle(0, 1'b1);
    repeat (50) cycle(0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_outport_arbiter
`default_nettype wire

// File: doc/outport_arbiter.md
# outport_arbiter

Per-output-port wormhole arbiter for the chiplet switch. Each input buffer presents its front flit's routed output port and tail flag. For every output port the block picks one buffer round-robin and locks that port to it until the packet's tail flit has been sent. While locked, it drives the crossbar select/enable and pops the owning buffer on each accepted flit. It sits between route compute / input buffers and the crossbar, and replaces per-flit switch allocation with packet-granular ownership.

## Interface
Parameters:
- NUM_BUFFERS, 5, number of input buffers (requesters)
- NUM_OUTPORTS, 5, number of output ports (resources)
- SEL_W, $clog2(NUM_BUFFERS), buffer index width
- PORT_W, $clog2(NUM_OUTPORTS), outport index width

Ports (clock/reset: one clock; reset is synchronous and active-high):
- clk  in  1  switch clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_BUFFERS  buffer i has a valid front flit
- req_port  in  NUM_BUFFERS x PORT_W  routed outport of buffer i's front flit
- req_tail  in  NUM_BUFFERS  buffer i's front flit is a tail (head-only packets also assert it)
- credit_avail  in  NUM_OUTPORTS  downstream of outport p can take a flit
- flit_sent  in  NUM_OUTPORTS  outport p accepted the flit presented this cycle
- grant_sel  out  NUM_OUTPORTS x SEL_W  crossbar select: owner buffer of outport p
- grant_en  out  NUM_OUTPORTS  crossbar enable: flit on outport p is valid
- buf_pop  out  NUM_BUFFERS  pop buffer i's front flit
- port_locked  out  NUM_OUTPORTS  outport p is owned
- protocol_err  out  1  sticky: flit_sent[p] was seen while grant_en[p]=0

## Operation
Each outport p has an independent FSM with two states, IDLE and LOCKED, plus registers owner[p] (SEL_W) and rr_ptr[p] (SEL_W).

- IDLE:
  - Candidates are buffers i with req[i]=1 and req_port[i]=p, excluding any buffer that already owns another port.
  - The winner is the first candidate at or after rr_ptr[p], searching upward with wrap.
  - If a winner exists: next state is LOCKED, owner[p] is set to the winner, and rr_ptr[p] is set to winner+1 (wrapping to 0 at NUM_BUFFERS).
- LOCKED:
  - grant_en[p] = req[owner] & credit_avail[p] & (req_port[owner]==p).
  - grant_sel[p] = owner[p] in both states. It is don't-care when grant_en is 0 but must be stable.
  - When grant_en[p] and flit_sent[p] are both high, buf_pop[owner] is asserted in the same cycle.
  - If req_tail[owner] is also high in that cycle, the next state is IDLE.
- buf_pop[i] is the OR over p of (grant_en[p] & flit_sent[p] & owner[p]==i). At most one port can own buffer i, so there is no double pop.
- When multiple outports are IDLE in the same cycle, each arbitrates independently. A buffer requests only one port, so there are no cross-port conflicts.

## Timing
- Reset values:
  - All FSMs in IDLE.
  - owner = 0 and rr_ptr = 0 for every port.
  - grant_en, buf_pop, port_locked and protocol_err are all 0.
  - grant_sel = 0.
- Latency:
  - A request in IDLE at cycle N gives port_locked at N+1.
  - The earliest grant_en is at N+1 (combinational from registered state and the live req/credit).
- Release: a tail sent at cycle N gives IDLE at N+1. A new lock is possible at N+2, so there is exactly one bubble cycle between packets on a port.
- Owner drops req mid-packet: the port stays LOCKED with grant_en=0 and no timeout.
- credit_avail low: grant_en=0 and the lock is held. flit_sent in that cycle sets protocol_err and changes no state.
- Single-flit packet (head with req_tail=1): the port is LOCKED for exactly one cycle if credit is present.
- rst asserted mid-packet: all locks are dropped next edge and the pointers return to 0. The packet remainder is the upstream's responsibility.
- rr_ptr wraps from NUM_BUFFERS-1 to 0. A non-power-of-two NUM_BUFFERS must not yield an out-of-range pointer.

## Structure
- Shared package: the FSM state enum arb_state_t {IDLE, LOCKED}.
- Sub-module rr_picker (parameter N) returns the first set bit at or after a pointer. It is purely combinational and instantiated once per outport.
- The arbiter holds the per-port FSM/registers in a generate loop, plus the buf_pop OR-reduction.

## Test plan
- Single request: req[2]=1, req_port[2]=1, credit=1, flit_sent=1, tail on third flit. Required response:
  - port_locked[1] rises next cycle.
  - buf_pop[2] fires 3 times.
  - IDLE after the tail, one bubble before any relock.
- Round-robin fairness: buffers 0, 1 and 3 all request port 4 with 1-flit packets continuously. Required response: grant order 0, 1, 3, 0, 1, 3, with each lock taking 2 cycles.
- Credit stall mid-packet: drop credit_avail[0] for 4 cycles during a 5-flit packet. Required response:
  - grant_en[0]=0 and no pops during the stall.
  - The lock is held and the remaining flits resume.
  - protocol_err stays 0.
- Parallel ports: buffer 0 sends to port 2 and buffer 1 sends to port 3 in the same cycle. Required response: both ports lock at N+1, and buf_pop[0] and buf_pop[1] can fire together.
- Interleave prevention: buffer 0 is locked on port 1 and buffer 3 requests port 1 mid-packet. Required response: buffer 3 waits until buffer 0's tail is sent, then locks 2 cycles later.
- Error and reset: flit_sent[2]=1 while port 2 is IDLE sets protocol_err. Then rst mid-packet on another port must produce the following on the next edge:
  - All port_locked = 0.
  - protocol_err = 0.
  - rr_ptr = 0.
